// File: rtl/cic_tx_pkg.sv
// rtl/cic_tx_pkg.sv - shared constants and types for the CIC transmit feeder
// Holds default sample width, FIFO depth and prefill threshold, the feeder
// state encoding and the packed I/Q pair type.
package cic_tx_pkg;

   localparam int CIC_W       = 18;
   localparam int CIC_DEPTH   = 16;
   localparam int CIC_PREFILL = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } feed_state_t;

   typedef struct packed {
      logic [CIC_W-1:0] i;
      logic [CIC_W-1:0] q;
   } iq_pair_t;

endpackage

// File: rtl/iq_fifo.sv
// rtl/iq_fifo.sv - single-clock I/Q pair FIFO with flush
// Ports: clk, rst (sync, active-high); push/wdata write side; pop/rdata read
// side (rdata shows the oldest entry, no read latency); flush empties the
// FIFO in one cycle; level/full/empty report occupancy.
module iq_fifo #(
   parameter int DEPTH = 16,
   parameter int DW    = 36
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push & ~full & ~flush & ~rst;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rptr[AW-1:0]];
   assign level = wptr - rptr;
   assign full  = (level == (AW+1)'(DEPTH));
   assign empty = (level == '0);

endmodule

// File: rtl/cic_tx_feeder.sv
// rtl/cic_tx_feeder.sv - transmit-side I/Q sample feeder for the CIC interpolator
// Ports: clk, rst (sync, active-high); xmt transmit enable; s_valid/s_ready/
// s_i/s_q upstream pair stream; tie per-sample request from the CIC;
// tdix/tdiy samples to the CIC; level FIFO occupancy; running (state RUN);
// under/ucnt sticky underflow flag and saturating count; clr clears both.
module cic_tx_feeder
   import cic_tx_pkg::*;
#(
   parameter int DEPTH   = CIC_DEPTH,
   parameter int W       = CIC_W,
   parameter int PREFILL = CIC_PREFILL
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      xmt,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [W-1:0]              s_i,
   input  logic [W-1:0]              s_q,
   input  logic                      tie,
   output logic [W-1:0]              tdix,
   output logic [W-1:0]              tdiy,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      running,
   output logic                      under,
   output logic [15:0]               ucnt,
   input  logic                      clr
);

   localparam int LW = $clog2(DEPTH) + 1;

   feed_state_t    state;
   feed_state_t    state_nx;
   logic           xmt_q;
   logic           flush;
   logic           push;
   logic           pop;
   logic           fwd;
   logic           uflow;
   logic           s_ready_r;
   logic           full;
   logic           empty;
   logic [2*W-1:0] rdata;
   logic [LW-1:0]  level_nx;
   logic [W-1:0]   tdix_nx;
   logic [W-1:0]   tdiy_nx;
   logic [15:0]    ucnt_r;

   // End of transmission is the falling edge of xmt; the FIFO empties then.
   assign flush   = xmt_q & ~xmt;
   assign s_ready = s_ready_r & ~flush & ~rst;
   assign push    = s_valid & s_ready & ~full;
   assign running = (state == RUN);
   assign ucnt    = ucnt_r;

   // A forwarded pair bypasses the FIFO entirely, so it is neither written nor read.
   iq_fifo #(
      .DEPTH (DEPTH),
      .DW    (2*W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push & ~fwd),
      .pop   (pop),
      .flush (flush),
      .wdata ({s_i, s_q}),
      .rdata (rdata),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      fwd      = 1'b0;
      uflow    = 1'b0;
      tdix_nx  = tdix;
      tdiy_nx  = tdiy;
      if (!xmt) begin
         state_nx = IDLE;
         tdix_nx  = '0;
         tdiy_nx  = '0;
      end else begin
         case (state)
            IDLE:  state_nx = PRIME;
            // Count a push arriving this cycle so output starts one cycle sooner.
            PRIME: if ((level + LW'(push)) >= LW'(PREFILL)) state_nx = RUN;
            RUN: begin
               if (tie) begin
                  if (!empty) begin
                     pop                = 1'b1;
                     {tdix_nx, tdiy_nx} = rdata;
                  end else if (push) begin
                     fwd     = 1'b1;
                     tdix_nx = s_i;
                     tdiy_nx = s_q;
                  end else begin
                     uflow    = 1'b1;
                     state_nx = PRIME;
                     tdix_nx  = '0;
                     tdiy_nx  = '0;
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   assign level_nx = flush ? '0 : (level + LW'(push & ~fwd) - LW'(pop));

   always_ff @(posedge clk) begin
      if (rst) begin
         xmt_q     <= 1'b0;
         s_ready_r <= 1'b0;
         tdix      <= '0;
         tdiy      <= '0;
         under     <= 1'b0;
         ucnt_r    <= '0;
      end else begin
         xmt_q     <= xmt;
         s_ready_r <= (level_nx != LW'(DEPTH));
         tdix      <= tdix_nx;
         tdiy      <= tdiy_nx;
         // An underflow in the same cycle as clr wins and starts a fresh count of one.
         if (uflow) begin
            under  <= 1'b1;
            ucnt_r <= clr ? 16'd1 : ((ucnt_r == 16'hFFFF) ? ucnt_r : ucnt_r + 16'd1);
         end else if (clr) begin
            under  <= 1'b0;
            ucnt_r <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cic_tx_feeder.sv
// tb/tb_cic_tx_feeder.sv - self-checking bench for cic_tx_feeder
module tb_cic_tx_feeder;

   localparam int W       = 18;
   localparam int DEPTH   = 16;
   localparam int PREFILL = 8;
   localparam int LW      = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          xmt;
   logic          s_valid;
   logic          s_ready;
   logic [W-1:0]  s_i;
   logic [W-1:0]  s_q;
   logic          tie;
   logic [W-1:0]  tdix;
   logic [W-1:0]  tdiy;
   logic [LW-1:0] level;
   logic          running;
   logic          under;
   logic [15:0]   ucnt;
   logic          clr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cic_tx_feeder #(
      .DEPTH   (DEPTH),
      .W       (W),
      .PREFILL (PREFILL)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .xmt     (xmt),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_i     (s_i),
      .s_q     (s_q),
      .tie     (tie),
      .tdix    (tdix),
      .tdiy    (tdiy),
      .level   (level),
      .running (running),
      .under   (under),
      .ucnt    (ucnt),
      .clr     (clr)
   );

   // Reference model: a queue of pairs plus the mode (0 idle, 1 prime, 2 run).
   logic [2*W-1:0] mq[$];
   int             m_mode;
   logic [W-1:0]   m_i;
   logic [W-1:0]   m_q;
   logic           m_under;
   logic [15:0]    m_ucnt;
   logic           m_rdy;
   logic           m_xprev;

   function automatic logic [W-1:0] rnd();
      return W'($urandom);
   endfunction

   function automatic logic [63:0] obsv();
      return {4'b0, tdix, tdiy, level, running, under, ucnt, s_ready};
   endfunction

   function automatic logic [63:0] expv();
      logic r;
      r = m_rdy && !(m_xprev && !xmt);
      return {4'b0, m_i, m_q, LW'(mq.size()), (m_mode == 2), m_under, m_ucnt, r};
   endfunction

   task automatic do_reset();
      rst     = 1'b1;
      s_valid = 1'($urandom);
      tie     = 1'($urandom);
      xmt     = 1'($urandom);
      clr     = 1'b0;
      s_i     = rnd();
      s_q     = rnd();
      @(posedge clk); #1;
      mq.delete();
      m_mode  = 0;
      m_i     = '0;
      m_q     = '0;
      m_under = 1'b0;
      m_ucnt  = '0;
      m_rdy   = 1'b0;
      m_xprev = 1'b0;
      rst     = 1'b0;
      s_valid = 1'b0;
      tie     = 1'b0;
      xmt     = 1'b0;
   endtask

   // Drive one cycle of inputs and advance the model by the feeder's rules.
   task automatic step(input logic v, input logic [W-1:0] i, input logic [W-1:0] q,
                       input logic t, input logic x, input logic c);
      logic fl, rdy, psh, uf;
      s_valid = v; s_i = i; s_q = q; tie = t; xmt = x; clr = c;
      fl  = m_xprev && !x;
      rdy = m_rdy && !fl;
      psh = v && rdy;
      uf  = 1'b0;
      if (!x) begin
         m_mode = 0;
         if (fl) mq.delete();
         else if (psh) mq.push_back({i, q});
         m_i = '0; m_q = '0;
      end else if (m_mode == 0) begin
         if (psh) mq.push_back({i, q});
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (psh) mq.push_back({i, q});
         if (mq.size() >= PREFILL) m_mode = 2;
      end else begin
         if (t && mq.size() > 0) begin
            {m_i, m_q} = mq.pop_front();
            if (psh) mq.push_back({i, q});
         end else if (t && psh) begin
            m_i = i; m_q = q;
         end else if (t) begin
            uf = 1'b1; m_i = '0; m_q = '0; m_mode = 1;
         end else if (psh) begin
            mq.push_back({i, q});
         end
      end
      if (uf) begin
         m_under = 1'b1;
         m_ucnt  = c ? 16'd1 : ((m_ucnt == 16'hFFFF) ? m_ucnt : m_ucnt + 16'd1);
      end else if (c) begin
         m_under = 1'b0;
         m_ucnt  = '0;
      end
      m_rdy   = (mq.size() != DEPTH);
      m_xprev = x;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (obsv() !== {4'b0, {(2*W){1'b0}}, {LW{1'b0}}, 3'b000, 16'h0000, 1'b0}) begin
         failures++;
         $display("FAIL reset_state got=%h exp=%h", obsv(), {4'b0, {(2*W){1'b0}}, {LW{1'b0}}, 3'b000, 16'h0000, 1'b0});
      end
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (s_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready_after got=%b exp=1", s_ready);
      end
   endtask

   task automatic test_prefill_run();
      do_reset();
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         step(1'b1, W'(k), W'(-k), 1'b0, 1'b1, 1'b0);
         checks++;
         if (obsv() !== expv()) begin
            failures++;
            $display("FAIL prefill_vec k=%0d got=%h exp=%h", k, obsv(), expv());
         end
      end
      checks++;
      if (running !== 1'b1) begin
         failures++;
         $display("FAIL prefill_running got=%b exp=1", running);
      end
      for (int j = 0; j < 8; j++) begin
         step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
         checks++;
         if (tdix !== W'(j) || tdiy !== W'(-j)) begin
            failures++;
            $display("FAIL run_order tie=%0d got=%h/%h exp=%h/%h", j, tdix, tdiy, W'(j), W'(-j));
         end
         for (int g = 0; g < 15; g++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (obsv() !== expv()) begin
               failures++;
               $display("FAIL run_hold tie=%0d got=%h exp=%h", j, obsv(), expv());
            end
         end
      end
   endtask

   task automatic test_underflow();
      do_reset();
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) step(1'b1, rnd(), rnd(), 1'b0, 1'b1, 1'b0);
      for (int j = 0; j < 9; j++) begin
         step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
         checks++;
         if (obsv() !== expv()) begin
            failures++;
            $display("FAIL under_vec tie=%0d got=%h exp=%h", j, obsv(), expv());
         end
         step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      end
      checks++;
      if (tdix !== '0 || tdiy !== '0 || under !== 1'b1 || ucnt !== 16'd1 || running !== 1'b0) begin
         failures++;
         $display("FAIL under_event got=%h/%h u=%b n=%h r=%b exp=0/0 u=1 n=0001 r=0", tdix, tdiy, under, ucnt, running);
      end
      for (int k = 0; k < 8; k++) step(1'b1, rnd(), rnd(), 1'b0, 1'b1, 1'b0);
      for (int j = 0; j < 4; j++) begin
         step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
         checks++;
         if (obsv() !== expv()) begin
            failures++;
            $display("FAIL under_resume tie=%0d got=%h exp=%h", j, obsv(), expv());
         end
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int k = 0; k < 16; k++) begin
         step(1'b1, rnd(), rnd(), 1'b0, 1'b0, 1'b0);
         checks++;
         if (obsv() !== expv()) begin
            failures++;
            $display("FAIL full_fill k=%0d got=%h exp=%h", k, obsv(), expv());
         end
      end
      step(1'b1, rnd(), rnd(), 1'b0, 1'b0, 1'b0);
      checks++;
      if (level !== LW'(16) || s_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_refuse got=lvl%0d rdy%b exp=lvl16 rdy0", level, s_ready);
      end
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (level !== LW'(15) || s_ready !== 1'b1) begin
         failures++;
         $display("FAIL full_release got=lvl%0d rdy%b exp=lvl15 rdy1", level, s_ready);
      end
      checks++;
      if (obsv() !== expv()) begin
         failures++;
         $display("FAIL full_pop_vec got=%h exp=%h", obsv(), expv());
      end
   endtask

   task automatic test_flush();
      do_reset();
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) step(1'b1, rnd(), rnd(), 1'b0, 1'b1, 1'b0);
      for (int j = 0; j < 3; j++) step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (level !== LW'(5) || running !== 1'b1) begin
         failures++;
         $display("FAIL flush_setup got=lvl%0d run%b exp=lvl5 run1", level, running);
      end
      xmt = 1'b0; s_valid = 1'b1; #1;
      checks++;
      if (s_ready !== 1'b0) begin
         failures++;
         $display("FAIL flush_ready got=%b exp=0", s_ready);
      end
      step(1'b1, rnd(), rnd(), 1'b0, 1'b0, 1'b0);
      checks++;
      if (level !== '0 || tdix !== '0 || tdiy !== '0 || running !== 1'b0) begin
         failures++;
         $display("FAIL flush_state got=lvl%0d %h/%h run%b exp=lvl0 0/0 run0", level, tdix, tdiy, running);
      end
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obsv() !== expv()) begin
         failures++;
         $display("FAIL flush_after got=%h exp=%h", obsv(), expv());
      end
   endtask

   task automatic test_simultaneous();
      logic [W-1:0] pi[8];
      logic [W-1:0] pq[8];
      logic [W-1:0] a, b, c, d;
      do_reset();
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         pi[k] = rnd(); pq[k] = rnd();
         step(1'b1, pi[k], pq[k], 1'b0, 1'b1, 1'b0);
      end
      for (int j = 0; j < 7; j++) step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      a = rnd(); b = rnd(); c = rnd(); d = rnd();
      step(1'b1, a, b, 1'b1, 1'b1, 1'b0);
      checks++;
      if (level !== LW'(1) || tdix !== pi[7] || tdiy !== pq[7]) begin
         failures++;
         $display("FAIL simul_pushpop got=lvl%0d %h/%h exp=lvl1 %h/%h", level, tdix, tdiy, pi[7], pq[7]);
      end
      step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (level !== '0 || tdix !== a || tdiy !== b) begin
         failures++;
         $display("FAIL simul_next got=lvl%0d %h/%h exp=lvl0 %h/%h", level, tdix, tdiy, a, b);
      end
      step(1'b1, c, d, 1'b1, 1'b1, 1'b0);
      checks++;
      if (level !== '0 || tdix !== c || tdiy !== d || under !== 1'b0 || running !== 1'b1) begin
         failures++;
         $display("FAIL simul_forward got=lvl%0d %h/%h u%b r%b exp=lvl0 %h/%h u0 r1", level, tdix, tdiy, under, running, c, d);
      end
   endtask

   task automatic test_random();
      logic xs;
      do_reset();
      xs = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 99) < 3) xs = ~xs;
         step(1'($urandom_range(0, 99) < 60), rnd(), rnd(), 1'($urandom_range(0, 99) < 12),
              xs, 1'($urandom_range(0, 99) < 2));
         checks++;
         if (obsv() !== expv()) begin
            failures++;
            $display("FAIL random_vec n=%0d got=%h exp=%h", n, obsv(), expv());
         end
      end
   endtask

   task automatic test_saturation();
      logic [15:0] want;
      do_reset();
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      force dut.ucnt_r = 16'hFFFC;
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      release dut.ucnt_r;
      m_ucnt = 16'hFFFC;
      for (int r = 1; r <= 5; r++) begin
         for (int k = 0; k < 8; k++) step(1'b1, rnd(), rnd(), 1'b0, 1'b1, 1'b0);
         for (int j = 0; j < 9; j++) step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
         want = (r <= 3) ? 16'hFFFC + 16'(r) : 16'hFFFF;
         checks++;
         if (ucnt !== want || under !== 1'b1) begin
            failures++;
            $display("FAIL sat_count round=%0d got=%h u%b exp=%h u1", r, ucnt, under, want);
         end
      end
      for (int k = 0; k < 8; k++) step(1'b1, rnd(), rnd(), 1'b0, 1'b1, 1'b0);
      for (int j = 0; j < 8; j++) step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (ucnt !== 16'd1 || under !== 1'b1) begin
         failures++;
         $display("FAIL clr_with_under got=%h u%b exp=0001 u1", ucnt, under);
      end
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (ucnt !== 16'd0 || under !== 1'b0) begin
         failures++;
         $display("FAIL clr_plain got=%h u%b exp=0000 u0", ucnt, under);
      end
      checks++;
      if (obsv() !== expv()) begin
         failures++;
         $display("FAIL clr_vec got=%h exp=%h", obsv(), expv());
      end
   endtask

   initial begin
      rst = 1'b1; xmt = 1'b0; s_valid = 1'b0; tie = 1'b0; clr = 1'b0;
      s_i = '0; s_q = '0;
      test_reset();
      test_prefill_run();
      test_underflow();
      test_full();
      test_flush();
      test_simultaneous();
      test_random();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cic_tx_feeder.md
# cic_tx_feeder

Transmit-side sample feeder for the 4-stage CIC interpolator. Accepts parallel I/Q pairs from the upstream modulator over a valid/ready stream and buffers them in a small FIFO. Delivers one pair to the interpolator's tdix/tdiy inputs on each one-cycle tie request. Provides prefill, underflow detection and flush on end of transmission, so the CIC always sees clean, stable data or zeros.

## Interface
- DEPTH, 16: FIFO depth in I/Q pairs; power of two, 4–256.
- W, 18: sample width per component.
- PREFILL, 8: pairs required in the FIFO before output starts; 1 ≤ PREFILL ≤ DEPTH.

- clk  in  1  master clock.
- rst  in  1  synchronous, active-high reset.
- xmt  in  1  transmit mode (1 = feeding active); same signal that drives the CIC transmit select.
- s_valid  in  1  upstream pair valid.
- s_ready  out  1  feeder can accept a pair.
- s_i  in  W  upstream I sample, two's complement.
- s_q  in  W  upstream Q sample, two's complement.
- tie  in  1  one-cycle request from the CIC for the next pair.
- tdix  out  W  I sample to the CIC.
- tdiy  out  W  Q sample to the CIC.
- level  out  log2(DEPTH)+1  current FIFO occupancy.
- running  out  1  state is RUN.
- under  out  1  sticky underflow flag.
- ucnt  out  16  underflow event count, saturating at 16'hFFFF.
- clr  in  1  clears under and ucnt.

## Operation
- FIFO write: s_valid & s_ready pushes {s_i, s_q}. The FIFO accepts writes in every state, so the host can preload before xmt rises.
  - s_ready = ~full, registered from next-state occupancy.
- States:
  - IDLE: tdix/tdiy = 0; tie ignored.
  - PRIME: tdix/tdiy = 0; tie ignored (no pop).
  - RUN: each tie pops one pair into the tdix/tdiy output registers.
- Transitions:
  - IDLE→PRIME when xmt=1.
  - PRIME→RUN when level ≥ PREFILL. The test uses level including a same-cycle push.
  - RUN→PRIME on underflow: tie with level=0 and no same-cycle push. On underflow, tdix/tdiy ← 0, under ← 1 and ucnt increments (saturating).
  - Any state→IDLE when xmt=0.
- xmt 1→0 (detected from a registered copy of xmt): the FIFO is flushed in that cycle; level=0 on the next cycle, and tdix/tdiy ← 0.
  - A write presented in the flush cycle is discarded, and s_ready is 0 in that cycle.
- Simultaneous push and tie-pop in RUN: level is unchanged, and the popped pair is the oldest entry.
  - Push into an empty FIFO coinciding with tie: the pair is forwarded. This is not an underflow.
- clr: clears under and ucnt in the next cycle. If an underflow occurs in the same cycle as clr, under=1 and ucnt=1.
- Arithmetic: samples pass through bit-exact with no scaling. Gain is owned by the CIC.

## Timing
- Reset values: state IDLE, level=0, s_ready=0 in the reset cycle and 1 afterwards, tdix=tdiy=0, running=0, under=0, ucnt=0.
- Pop latency: tie in cycle t → new tdix/tdiy valid from cycle t+1 and held stable until the cycle after the next tie.
- Tie spacing: the CIC guarantees ≥16 clk cycles between ties (interpolation factor ≥8). The feeder does not require this.
- Write latency: a pushed pair is counted in level the next cycle.
- Full: s_ready=0 while level=DEPTH, unless a same-cycle pop is in progress; s_ready is registered and conservative.
- Reset mid-operation: all state returns to reset values in the next cycle, and FIFO contents are discarded.

## Structure
- Package cic_tx_pkg holds:
  - the default W/DEPTH/PREFILL constants;
  - the state typedef (IDLE, PRIME, RUN);
  - the packed pair type {i, q}.
- Sub-module iq_fifo: synchronous single-clock FIFO with DEPTH×2W distributed RAM, pointers one bit wider than the address, and push, pop, flush, level, full and empty. It is reused later on the receive side.
- Top level contains the state machine, output registers, and underflow logic.

## Test plan
- Prefill and run: with PREFILL=8, push 8 pairs (i=k, q=−k) with xmt=1, then issue ties every 16 cycles. Required: running rises after the 8th push; tdix/tdiy = 0, −0; 1, −1; … in order, each appearing the cycle after its tie.
- Underflow: push 8 pairs, issue 9 ties. Required: the 9th tie gives tdix=tdiy=0, under=1, ucnt=1, state PRIME. Then push 8 more and confirm RUN resumes with the new data.
- Full backpressure: with xmt=0, push 16 pairs; s_ready falls and a 17th push is refused (level stays 16). Raise xmt, then tie once: level=15 and s_ready returns to 1.
- Flush: in RUN with level=5, drop xmt. Required: level=0 next cycle, tdix=tdiy=0, state IDLE; a push in the flush cycle is not stored.
- Simultaneous push and pop: in RUN with level=1, issue a push and a tie in the same cycle. Required: level stays 1 and the old pair is output. At level=0, a push with tie forwards the new pair with no underflow.
- Saturation and clear: force 65 540 underflows, then check ucnt=FFFF; assert clr and confirm ucnt=0 and under=0.
